beta_if_prefetch_stage: RTL and testbench

- Parametrised successor of the single-request fetch stage. Sits between instruction memory and decode.
- Keeps up to MaxOutstanding in-order memory requests in flight and buffers returned instructions, each tagged with its PC, in a FifoDepth-entry prefetch FIFO.
- Supports redirect (branch/exception) with flush and discard of stale in-flight responses.
- Decode consumes instructions through a valid/ready handshake.

---
 rtl/beta_pkg.sv | 24 ++
 rtl/beta_if_prefetch_fifo.sv | 75 +++++++
 rtl/beta_if_prefetch_stage.sv | 189 ++++++++++++++++++
 tb/tb_beta_if_prefetch_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/beta_pkg.sv
`default_nettype none
// ============================================================================
// beta_pkg : shared types and constants for the beta instruction-fetch stage
// Revision : 1.0
// ============================================================================
package beta_pkg;

   localparam int INSTR_BYTES  = 4;
   localparam int IF_MAX_WIDTH = 64;

   typedef enum logic [1:0] {
      IF_IDLE  = 2'd0,
      IF_RUN   = 2'd1,
      IF_FLUSH = 2'd2
   } if_state_e;

   // Sized for the widest supported datapath; narrower builds leave the top bits constant.
   typedef struct packed {
      logic [IF_MAX_WIDTH-1:0] instr;
      logic [IF_MAX_WIDTH-1:0] pc;
   } if_fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/beta_if_prefetch_fifo.sv
`default_nettype none
// ============================================================================
// beta_if_prefetch_fifo : power-of-two circular buffer with synchronous flush
// Revision : 1.0
// ============================================================================
module beta_if_prefetch_fifo #(
   parameter int DEPTH   = 4,
   parameter int ENTRY_W = 128
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [ENTRY_W-1:0]         push_data_i,
   input  logic                       pop_i,
   output logic [ENTRY_W-1:0]         head_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = $clog2(DEPTH+1);

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0] r_count;
   logic               w_push;
   logic               w_pop;

   assign w_pop   = pop_i && !empty_o;
   // A push into a full buffer is only safe when the head leaves in the same cycle.
   assign w_push  = push_i && (!full_o || w_pop);
   assign full_o  = (r_count == c_cnt_w'(DEPTH));
   assign empty_o = (r_count == '0);
   assign head_o  = r_mem[r_rd_ptr];
   assign count_o = r_count;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push && !flush_i) begin
         r_mem[r_wr_ptr] <= push_data_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/beta_if_prefetch_stage.sv
`default_nettype none
// ============================================================================
// beta_if_prefetch_stage : in-order multi-request instruction prefetch stage
// Revision : 1.0
// ============================================================================
module beta_if_prefetch_stage
   import beta_pkg::*;
#(
   parameter int                    DATA_WIDTH      = 32,
   parameter int                    FIFO_DEPTH      = 4,
   parameter int                    MAX_OUTSTANDING = 2,
   parameter logic [DATA_WIDTH-1:0] BOOT_ADDR       = '0
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            if_fetch_en_i,
   output logic                            if_instr_req_o,
   output logic [DATA_WIDTH-1:0]           if_instr_addr_o,
   input  logic                            if_instr_ready_i,
   input  logic                            if_instr_valid_i,
   input  logic [DATA_WIDTH-1:0]           if_instr_rdata_i,
   input  logic                            if_redirect_i,
   input  logic [DATA_WIDTH-1:0]           if_redirect_pc_i,
   output logic [DATA_WIDTH-1:0]           if_instr_o,
   output logic [DATA_WIDTH-1:0]           if_instr_pc_o,
   output logic                            if_instr_valid_o,
   input  logic                            if_dec_ready_i,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] if_fifo_count_o,
   output logic                            if_stage_busy_o
);

   localparam int                    c_out_w   = $clog2(MAX_OUTSTANDING+1);
   localparam int                    c_cnt_w   = $clog2(FIFO_DEPTH+1);
   localparam logic [DATA_WIDTH-1:0] c_pc_step = DATA_WIDTH'(INSTR_BYTES);

   if_state_e             r_state;
   if_state_e             w_state_next;
   logic [DATA_WIDTH-1:0] r_fetch_pc;
   logic [DATA_WIDTH-1:0] r_resp_pc;
   logic [DATA_WIDTH-1:0] w_redirect_pc;
   logic [c_out_w-1:0]    r_outstanding;
   logic [c_out_w-1:0]    w_outstanding_next;
   logic [c_out_w-1:0]    r_discard;
   logic [c_out_w-1:0]    w_discard_next;
   logic [c_cnt_w-1:0]    w_fifo_count;
   logic                  w_fifo_empty;
   logic                  w_fifo_full;
   logic                  w_credit_ok;
   logic                  w_grant;
   logic                  w_resp_ok;
   logic                  w_push;
   logic                  w_pop;
   if_fifo_entry_t        w_push_entry;
   if_fifo_entry_t        w_head;

   assign w_redirect_pc = {if_redirect_pc_i[DATA_WIDTH-1:2], 2'b00};

   // Buffered plus in-flight instructions may never exceed the FIFO, so every response has a slot.
   assign w_credit_ok = (int'(r_outstanding) < MAX_OUTSTANDING) &&
                        ((int'(r_outstanding) + int'(w_fifo_count)) < FIFO_DEPTH);

   assign if_instr_req_o  = (r_state == IF_RUN) && if_fetch_en_i && !if_redirect_i && w_credit_ok;
   assign if_instr_addr_o = r_fetch_pc;
   assign w_grant         = if_instr_req_o && if_instr_ready_i;
   assign w_resp_ok       = if_instr_valid_i && (r_outstanding != '0);
   assign w_push          = w_resp_ok && (r_discard == '0) && !if_redirect_i;
   assign w_pop           = if_instr_valid_o && if_dec_ready_i;

   assign w_push_entry.instr = IF_MAX_WIDTH'(if_instr_rdata_i);
   assign w_push_entry.pc    = IF_MAX_WIDTH'(r_resp_pc);

   always_comb begin
      w_outstanding_next = r_outstanding;
      if (w_grant && !w_resp_ok) begin
         w_outstanding_next = r_outstanding + c_out_w'(1);
      end else if (!w_grant && w_resp_ok) begin
         w_outstanding_next = r_outstanding - c_out_w'(1);
      end
   end

   // A response arriving with the redirect is already excluded from the next outstanding count.
   always_comb begin
      w_discard_next = r_discard;
      if (if_redirect_i) begin
         w_discard_next = w_outstanding_next;
      end else if (w_resp_ok && (r_discard != '0)) begin
         w_discard_next = r_discard - c_out_w'(1);
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (if_redirect_i) begin
         if (w_discard_next != '0) begin
            w_state_next = IF_FLUSH;
         end else if (if_fetch_en_i) begin
            w_state_next = IF_RUN;
         end else begin
            w_state_next = IF_IDLE;
         end
      end else begin
         case (r_state)
            IF_IDLE: begin
               if (if_fetch_en_i) begin
                  w_state_next = IF_RUN;
               end
            end
            IF_RUN: begin
               if (!if_fetch_en_i && (r_outstanding == '0)) begin
                  w_state_next = IF_IDLE;
               end
            end
            IF_FLUSH: begin
               if (w_discard_next == '0) begin
                  if (if_fetch_en_i) begin
                     w_state_next = IF_RUN;
                  end else begin
                     w_state_next = IF_IDLE;
                  end
               end
            end
            default: w_state_next = IF_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state       <= IF_IDLE;
         r_fetch_pc    <= BOOT_ADDR;
         r_resp_pc     <= BOOT_ADDR;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         r_state       <= w_state_next;
         r_outstanding <= w_outstanding_next;
         r_discard     <= w_discard_next;
         if (if_redirect_i) begin
            r_fetch_pc <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
         end else begin
            if (w_grant) begin
               r_fetch_pc <= r_fetch_pc + c_pc_step;
            end
            if (w_push) begin
               r_resp_pc <= r_resp_pc + c_pc_step;
            end
         end
      end
   end

   beta_if_prefetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .ENTRY_W ($bits(if_fifo_entry_t))
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (if_redirect_i),
      .push_i      (w_push),
      .push_data_i (w_push_entry),
      .pop_i       (w_pop),
      .head_o      (w_head),
      .full_o      (w_fifo_full),
      .empty_o     (w_fifo_empty),
      .count_o     (w_fifo_count)
   );

   assign if_instr_o       = w_head.instr[DATA_WIDTH-1:0];
   assign if_instr_pc_o    = w_head.pc[DATA_WIDTH-1:0];
   assign if_instr_valid_o = !w_fifo_empty && (r_state != IF_FLUSH);
   assign if_fifo_count_o  = w_fifo_count;
   assign if_stage_busy_o  = (r_outstanding != '0) || (r_state != IF_IDLE);

   generate
      if (DATA_WIDTH < IF_MAX_WIDTH) begin : g_narrow_entry
         logic w_unused_head;
         assign w_unused_head = ^{w_head.instr[IF_MAX_WIDTH-1:DATA_WIDTH],
                                  w_head.pc[IF_MAX_WIDTH-1:DATA_WIDTH]};
      end
   endgenerate

   a_resp_without_request: assert property (@(posedge clk_i) disable iff (rst_i)
      !(if_instr_valid_i && (r_outstanding == '0)));

   a_no_fifo_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(w_push && w_fifo_full && !w_pop));

endmodule
`default_nettype wire

// File: tb/tb_beta_if_prefetch_stage.sv
`default_nettype none
// ============================================================================
// tb_beta_if_prefetch_stage : directed self-checking bench for the prefetch stage
// Revision : 1.0
// ============================================================================
module tb_beta_if_prefetch_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_fetch_en_i;
   logic        if_instr_req_o;
   logic [31:0] if_instr_addr_o;
   logic        if_instr_ready_i;
   logic        if_instr_valid_i;
   logic [31:0] if_instr_rdata_i;
   logic        if_redirect_i;
   logic [31:0] if_redirect_pc_i;
   logic [31:0] if_instr_o;
   logic [31:0] if_instr_pc_o;
   logic        if_instr_valid_o;
   logic        if_dec_ready_i;
   logic [2:0]  if_fifo_count_o;
   logic        if_stage_busy_o;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_grants = 0;
   logic        resp_en;
   logic [31:0] pend[$];

   always #5 clk_i = ~clk_i;

   beta_if_prefetch_stage #(
      .DATA_WIDTH      (32),
      .FIFO_DEPTH      (4),
      .MAX_OUTSTANDING (2),
      .BOOT_ADDR       (32'h0)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .if_fetch_en_i    (if_fetch_en_i),
      .if_instr_req_o   (if_instr_req_o),
      .if_instr_addr_o  (if_instr_addr_o),
      .if_instr_ready_i (if_instr_ready_i),
      .if_instr_valid_i (if_instr_valid_i),
      .if_instr_rdata_i (if_instr_rdata_i),
      .if_redirect_i    (if_redirect_i),
      .if_redirect_pc_i (if_redirect_pc_i),
      .if_instr_o       (if_instr_o),
      .if_instr_pc_o    (if_instr_pc_o),
      .if_instr_valid_o (if_instr_valid_o),
      .if_dec_ready_i   (if_dec_ready_i),
      .if_fifo_count_o  (if_fifo_count_o),
      .if_stage_busy_o  (if_stage_busy_o)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory stub: answers each grant one cycle later with data = addr ^ 0xDEAD0000.
   task automatic cycle();
      logic        g;
      logic [31:0] a;
      g = if_instr_req_o & if_instr_ready_i;
      a = if_instr_addr_o;
      @(posedge clk_i);
      #1;
      if (g) begin
         pend.push_back(a);
         n_grants++;
      end
      if (resp_en && (pend.size() != 0)) begin
         a = pend.pop_front();
         if_instr_valid_i = 1'b1;
         if_instr_rdata_i = a ^ 32'hDEAD_0000;
      end else begin
         if_instr_valid_i = 1'b0;
         if_instr_rdata_i = '0;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_i            = 1'b1;
      if_fetch_en_i    = 1'b0;
      if_instr_ready_i = 1'b0;
      if_instr_valid_i = 1'b0;
      if_instr_rdata_i = '0;
      if_redirect_i    = 1'b0;
      if_redirect_pc_i = '0;
      if_dec_ready_i   = 1'b0;
      resp_en          = 1'b0;
      pend.delete();
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      #1;
   endtask

   task automatic set_run(input logic rsp, input logic dec);
      if_fetch_en_i    = 1'b1;
      if_instr_ready_i = 1'b1;
      resp_en          = rsp;
      if_dec_ready_i   = dec;
      #1;
   endtask

   task automatic redirect_cycle(input logic [31:0] pc);
      if_redirect_i    = 1'b1;
      if_redirect_pc_i = pc;
      #1;
      cycle();
      if_redirect_i = 1'b0;
      #1;
   endtask

   logic [31:0] exp_pc [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};

   initial begin
      // Reset values
      do_reset();
      chk("rst_req",   if_instr_req_o,   0);
      chk("rst_addr",  if_instr_addr_o,  32'h0);
      chk("rst_valid", if_instr_valid_o, 0);
      chk("rst_count", if_fifo_count_o,  0);
      chk("rst_busy",  if_stage_busy_o,  0);
      chk("rst_instr", if_instr_o,       0);
      chk("rst_pc",    if_instr_pc_o,    0);

      // Streaming at one instruction per cycle
      set_run(1'b1, 1'b1);
      chk("t1_idle_req", if_instr_req_o, 0);
      cycle();
      chk("t1_req",  if_instr_req_o,  1);
      chk("t1_addr", if_instr_addr_o, 32'h0);
      cycle();
      cycle();
      chk("t1_addr8", if_instr_addr_o, 32'h8);
      for (int k = 0; k < 4; k++) begin
         chk("t1_valid", if_instr_valid_o, 1);
         chk("t1_pc",    if_instr_pc_o,    exp_pc[k]);
         chk("t1_instr", if_instr_o,       exp_pc[k] ^ 32'hDEAD_0000);
         cycle();
      end

      // Back-pressure fills the FIFO, then drains in order
      do_reset();
      set_run(1'b1, 1'b0);
      n_grants = 0;
      repeat (12) cycle();
      chk("t2_grants", n_grants,        4);
      chk("t2_count",  if_fifo_count_o, 4);
      chk("t2_req",    if_instr_req_o,  0);
      chk("t2_busy",   if_stage_busy_o, 1);
      if_dec_ready_i = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) begin
         chk("t2_valid", if_instr_valid_o, 1);
         chk("t2_pc",    if_instr_pc_o,    exp_pc[k]);
         chk("t2_instr", if_instr_o,       exp_pc[k] ^ 32'hDEAD_0000);
         cycle();
      end

      // Redirect with two responses in flight
      do_reset();
      set_run(1'b0, 1'b1);
      redirect_cycle(32'h10);
      chk("t3_addr10", if_instr_addr_o, 32'h10);
      chk("t3_req10",  if_instr_req_o,  1);
      cycle();
      cycle();
      chk("t3_req_cap", if_instr_req_o,  0);
      chk("t3_busy",    if_stage_busy_o, 1);
      resp_en = 1'b1;
      redirect_cycle(32'h103);
      chk("t3_fl_valid", if_instr_valid_o, 0);
      chk("t3_fl_req",   if_instr_req_o,   0);
      chk("t3_fl_addr",  if_instr_addr_o,  32'h100);
      cycle();
      chk("t3_fl_req1",   if_instr_req_o,   0);
      chk("t3_fl_valid1", if_instr_valid_o, 0);
      cycle();
      chk("t3_req",    if_instr_req_o,   1);
      chk("t3_addr",   if_instr_addr_o,  32'h100);
      chk("t3_valid0", if_instr_valid_o, 0);
      chk("t3_count0", if_fifo_count_o,  0);
      cycle();
      cycle();
      chk("t3_valid", if_instr_valid_o, 1);
      chk("t3_pc",    if_instr_pc_o,    32'h100);
      chk("t3_instr", if_instr_o,       32'hDEAD_0100);

      // Redirect coinciding with a response and a decode pop
      do_reset();
      set_run(1'b1, 1'b0);
      repeat (4) cycle();
      chk("t4_count2", if_fifo_count_o,  2);
      chk("t4_resp",   if_instr_valid_i, 1);
      if_dec_ready_i = 1'b1;
      redirect_cycle(32'h40);
      chk("t4_count", if_fifo_count_o,  0);
      chk("t4_valid", if_instr_valid_o, 0);
      chk("t4_req",   if_instr_req_o,   1);
      chk("t4_addr",  if_instr_addr_o,  32'h40);
      cycle();
      cycle();
      chk("t4_nvalid", if_instr_valid_o, 1);
      chk("t4_npc",    if_instr_pc_o,    32'h40);
      chk("t4_ninstr", if_instr_o,       32'hDEAD_0040);

      // Address wrap at the top of the address space
      do_reset();
      set_run(1'b1, 1'b1);
      redirect_cycle(32'hFFFF_FFFE);
      chk("t5_addr_top", if_instr_addr_o, 32'hFFFF_FFFC);
      chk("t5_req",      if_instr_req_o,  1);
      cycle();
      chk("t5_addr_wrap", if_instr_addr_o, 32'h0);
      cycle();
      chk("t5_pc_top",    if_instr_pc_o, 32'hFFFF_FFFC);
      chk("t5_instr_top", if_instr_o,    32'h2152_FFFC);
      cycle();
      chk("t5_pc_wrap",    if_instr_pc_o, 32'h0);
      chk("t5_instr_wrap", if_instr_o,    32'hDEAD_0000);

      // Asynchronous reset in the middle of a burst
      do_reset();
      set_run(1'b0, 1'b1);
      redirect_cycle(32'h200);
      cycle();
      cycle();
      chk("t6_busy", if_stage_busy_o, 1);
      chk("t6_addr", if_instr_addr_o, 32'h208);
      #2 rst_i = 1'b1;
      #1;
      chk("t6_rst_req",   if_instr_req_o,   0);
      chk("t6_rst_addr",  if_instr_addr_o,  32'h0);
      chk("t6_rst_busy",  if_stage_busy_o,  0);
      chk("t6_rst_valid", if_instr_valid_o, 0);
      chk("t6_rst_count", if_fifo_count_o,  0);
      pend.delete();
      if_instr_valid_i = 1'b0;
      #2 rst_i = 1'b0;
      resp_en = 1'b1;
      #1;
      cycle();
      chk("t6_addr_boot", if_instr_addr_o, 32'h0);
      chk("t6_req_boot",  if_instr_req_o,  1);
      cycle();
      chk("t6_no_stale", if_instr_valid_o, 0);
      cycle();
      chk("t6_valid", if_instr_valid_o, 1);
      chk("t6_pc",    if_instr_pc_o,    32'h0);
      chk("t6_instr", if_instr_o,       32'hDEAD_0000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
